shift_seq_ctrl: RTL and testbench

//   Sequencer for the serial shift-register datapath. Accepts a parallel word over a

---
 rtl/shift_seq_pkg.sv | 15 +
 rtl/shift_chain.sv | 26 ++
 rtl/shift_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the serial shift sequencer.
// Build option: SHIFT_SEQ_PARITY_EN adds the PAR bit period (see shift_seq_ctrl).
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      DONE  = 2'd3
   } shift_seq_state_t;

   // div_cnt width; DIV up to 255 fits.
   localparam int DIV_W = 8;

endpackage

// File: rtl/shift_chain.sv
// Parallel-in, serial-out register: load wins over shift, MSB leaves first.
module shift_chain
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q_msb
);

   logic [WIDTH-1:0] sreg;

   // Load a fresh word, or move the chain one place toward the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     sreg <= '0;
      else if (load)  sreg <= d;
      else if (shift) sreg <= {sreg[WIDTH-2:0], 1'b0};
   end

   assign q_msb = sreg[WIDTH-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: accepts a word on valid/ready, shifts it out MSB first,
// one bit every DIV clocks, with a per-bit strobe and a completion pulse.
// Build option: SHIFT_SEQ_PARITY_EN appends one even-parity bit period (state PAR).
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             abort,
   output logic             ser_out,
   output logic             ser_en,
   output logic             busy,
   output logic             done
);

   localparam int               BCW      = $clog2(WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BCW-1:0]   BIT_LAST = BCW'(WIDTH - 1);

   shift_seq_state_t state, nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [BCW-1:0]   bit_cnt;
   logic             msb;
   logic             load;
   logic             shift_en;
   logic             div_end;
   logic             last_bit;

   assign div_end  = (div_cnt == DIV_LAST);
   assign last_bit = div_end && (bit_cnt == BIT_LAST);

   shift_chain #(.WIDTH(WIDTH)) u_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift_en),
      .d     (in_data),
      .q_msb (msb)
   );

`ifdef SHIFT_SEQ_PARITY_EN
   logic par_bit;

   // Even parity of the accepted word, sent after the last data bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    par_bit <= 1'b0;
      else if (load) par_bit <= ^in_data;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next state and outputs; abort overrides every transition.
   always_comb begin
      nxt      = state;
      in_ready = 1'b0;
      ser_out  = 1'b0;
      ser_en   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            // rst_n gating keeps in_ready low for the whole reset pulse
            in_ready = rst_n && !abort;
            if (in_valid && rst_n && !abort) begin
               load = 1'b1;
               nxt  = SHIFT;
            end
         end
         SHIFT: begin
            ser_out  = msb;
            ser_en   = (div_cnt == '0);
            busy     = 1'b1;
            shift_en = div_end;
`ifdef SHIFT_SEQ_PARITY_EN
            if (last_bit) nxt = PAR;
`else
            if (last_bit) nxt = DONE;
`endif
         end
`ifdef SHIFT_SEQ_PARITY_EN
         PAR: begin
            ser_out = par_bit;
            ser_en  = (div_cnt == '0);
            busy    = 1'b1;
            if (div_end) nxt = DONE;
         end
`endif
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end

   // Bit-period and bit counters; idle outside the shifting states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (abort || state == IDLE || state == DONE) begin
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (div_end) begin
         div_cnt <= '0;
         bit_cnt <= bit_cnt + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: the driver predicts acceptance from a
// timing model and queues the expected strobe/done events; a negedge monitor
// pops and compares them, and checks busy/ser_out against the modelled word.
module tb_shift_seq_ctrl;

   localparam int WIDTH = 8;
   localparam int DIV   = 3;
`ifdef SHIFT_SEQ_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready, ser_out, ser_en, busy, done;

   typedef struct {
      int cyc;
      bit val;
      bit is_done;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  free_cyc = 0;
   int  m_t = -1;
   int  m_bend = -1;
   bit  m_bits [NB];
   bit  mon_on = 1'b0;

   shift_seq_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .abort    (abort),
      .ser_out  (ser_out),
      .ser_en   (ser_en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // One cycle of stimulus; the model decides acceptance and abort effects.
   task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit a, output bit acc);
      in_valid = v;
      in_data  = d;
      abort    = a;
      #1;
      chk("in_ready", in_ready, int'((cyc >= free_cyc) && !a));
      acc = v && !a && (cyc >= free_cyc);
      if (a && cyc < free_cyc) begin
         while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
         free_cyc = cyc + 1;
         if (m_bend > cyc) m_bend = cyc;
      end
      if (acc) begin
         for (int k = 0; k < WIDTH; k++) m_bits[k] = d[WIDTH-1-k];
`ifdef SHIFT_SEQ_PARITY_EN
         m_bits[WIDTH] = ^d;
`endif
         for (int k = 0; k < NB; k++) sb.push_back('{cyc + 1 + k*DIV, m_bits[k], 1'b0});
         sb.push_back('{cyc + 1 + NB*DIV, 1'b0, 1'b1});
         m_t      = cyc;
         m_bend   = cyc + NB*DIV;
         free_cyc = cyc + 2 + NB*DIV;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
   endtask

   // Hold in_valid with one word until the model says it was taken.
   task automatic send_word(input logic [WIDTH-1:0] d);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
         step(1'b1, d, 1'b0, acc);
         n++;
      end
      if (!acc) begin
         failures++;
         $display("FAIL send_timeout cyc=%0d actual=not_taken required=taken", cyc);
      end
   endtask

   // Async reset pulse between clock edges; outputs must drop at once.
   task automatic pulse_reset();
      in_valid = 1'b0;
      abort    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ser_out", ser_out, 0);
      chk("rst_ser_en", ser_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      #2 rst_n = 1'b1;
      sb.delete();
      free_cyc = cyc;
      m_t = -1;
      m_bend = -1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: per-cycle busy/ser_out, plus scoreboard of strobes and done.
   always @(negedge clk) begin
      bit exp_busy, exp_ser, have, exp_en, exp_done;
      if (mon_on && rst_n) begin
         exp_busy = (cyc > m_t) && (cyc <= m_bend);
         exp_ser  = exp_busy ? m_bits[(cyc - m_t - 1) / DIV] : 1'b0;
         chk("busy", busy, int'(exp_busy));
         chk("ser_out", ser_out, int'(exp_ser));
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            failures++;
            $display("FAIL missed_event cyc=%0d actual=none required=event@%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         have     = (sb.size() > 0) && (sb[0].cyc == cyc);
         exp_en   = have && !sb[0].is_done;
         exp_done = have && sb[0].is_done;
         chk("ser_en", ser_en, int'(exp_en));
         chk("done", done, int'(exp_done));
         if (exp_en) chk("bit_value", ser_out, int'(sb[0].val));
         if (have) void'(sb.pop_front());
      end
   end

   initial begin
      bit acc;
      bit v, a;
      logic [WIDTH-1:0] d;
      int n;
      #3;
      chk("init_ser_out", ser_out, 0);
      chk("init_ser_en", ser_en, 0);
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_in_ready", in_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      free_cyc = cyc;
      mon_on = 1'b1;

      // single words, one-cycle valid
      step(1'b1, 8'hA5, 1'b0, acc);
      idle(30);
      step(1'b1, 8'h81, 1'b0, acc);
      idle(30);

      // abort at t+5, new word right after
      step(1'b1, 8'hFF, 1'b0, acc);
      idle(4);
      step(1'b0, '0, 1'b1, acc);
      step(1'b1, 8'h3C, 1'b0, acc);
      idle(30);

      // valid held high across back-to-back words
      send_word(8'h01);
      send_word(8'h02);
      send_word(8'h07);
      send_word(8'h03);
      idle(30);

      // reset mid-word, then abort racing in_valid in IDLE
      step(1'b1, 8'hC3, 1'b0, acc);
      idle(5);
      pulse_reset();
      step(1'b1, 8'h5A, 1'b1, acc);
      idle(2);
      step(1'b1, 8'h5A, 1'b0, acc);
      idle(30);

      // random traffic with rare abort and reset
      for (int i = 0; i < 600; i++) begin
         v = ($urandom_range(0, 9) < 7);
         a = ($urandom_range(0, 29) == 0);
         d = WIDTH'($urandom);
         if ($urandom_range(0, 249) == 0) pulse_reset();
         else step(v, d, a, acc);
      end

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         idle(1);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
